// File: rtl/mul_unit.sv
// mul_unit: multi-cycle shift-add multiplier for the picoMIPS datapath.
// Operands come from the register file read buses; the selected half of the
// product is written back through Wdata/Wdno with a one-cycle w strobe.
// RUN always takes n cycles, followed by a single WB cycle.
// Optional feature: define MUL_SIGNED_EN for two's complement operands.
module mul_unit #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic [1:0]     dest,
  input  logic           hi,
  output logic           busy,
  output logic           w,
  output logic [1:0]     Wdno,
  output logic [n-1:0]   Wdata,
  output logic [2*n-1:0] prod
);

  localparam int CW = $clog2(n) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WB
  } state_t;

  state_t         state_q, state_d;

  logic [2*n-1:0] mcand_q, mcand_d;
  logic [n-1:0]   mplier_q, mplier_d;
  logic [2*n-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     dest_q, dest_d;
  logic           hi_q, hi_d;

  logic           busy_q, busy_d;
  logic           w_q, w_d;
  logic [1:0]     wdno_q, wdno_d;
  logic [n-1:0]   wdata_q, wdata_d;
  logic [2*n-1:0] prod_q, prod_d;

  logic           last_iter;
  logic [2*n-1:0] addend;
  logic [2*n-1:0] acc_step;
  logic [2*n-1:0] mcand_ext;

  assign last_iter = (cnt_q == CW'(n - 1));
  assign addend    = mplier_q[0] ? mcand_q : '0;

`ifdef MUL_SIGNED_EN
  // The multiplier MSB carries negative weight, so the final partial product is subtracted.
  assign acc_step  = last_iter ? (acc_q - addend) : (acc_q + addend);
  assign mcand_ext = {{n{a[n-1]}}, a};
`else
  assign acc_step  = acc_q + addend;
  assign mcand_ext = {{n{1'b0}}, a};
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start only honoured in IDLE; RUN exits after n iterations.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    hi_d     = hi_q;
    w_d      = 1'b0;
    wdno_d   = wdno_q;
    wdata_d  = wdata_q;
    prod_d   = prod_q;
    busy_d   = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = mcand_ext;
          mplier_d = b;
          dest_d   = dest;
          hi_d     = hi;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Results are taken from the final sum so they are registered on entry to WB.
        if (last_iter) begin
          w_d     = 1'b1;
          wdno_d  = dest_q;
          wdata_d = hi_q ? acc_step[2*n-1:n] : acc_step[n-1:0];
          prod_d  = acc_step;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dest_q   <= '0;
      hi_q     <= 1'b0;
      busy_q   <= 1'b0;
      w_q      <= 1'b0;
      wdno_q   <= '0;
      wdata_q  <= '0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dest_q   <= dest_d;
      hi_q     <= hi_d;
      busy_q   <= busy_d;
      w_q      <= w_d;
      wdno_q   <= wdno_d;
      wdata_q  <= wdata_d;
      prod_q   <= prod_d;
    end
  end

  assign busy  = busy_q;
  assign w     = w_q;
  assign Wdno  = wdno_q;
  assign Wdata = wdata_q;
  assign prod  = prod_q;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed-vector bench for mul_unit (n=8).
// Expected values are hand-computed; MUL_SIGNED_EN selects the signed set.
module tb_mul_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  dest;
  logic        hi;
  logic        busy;
  logic        w;
  logic [1:0]  Wdno;
  logic [7:0]  Wdata;
  logic [15:0] prod;

  int total;
  int bad;

  mul_unit #(.n(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .dest  (dest),
    .hi    (hi),
    .busy  (busy),
    .w     (w),
    .Wdno  (Wdno),
    .Wdata (Wdata),
    .prod  (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and watch 14 cycles. mode=1 pulses start mid-RUN and
  // in WB and changes the operand/dest inputs while the operation is in flight.
  task automatic run_op(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic [1:0] di, input logic hii, input int mode,
                        input logic [7:0] exp_wdata, input logic [15:0] exp_prod,
                        input logic [1:0] exp_wdno);
    int wcnt;
    int wpos;
    int bcnt;
    logic [7:0] wd_at;
    logic [1:0] wn_at;
    wcnt = 0; wpos = 0; bcnt = 0; wd_at = '0; wn_at = '0;
    a = ai; b = bi; dest = di; hi = hii; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      if (busy) bcnt++;
      if (w) begin
        wcnt++;
        if (wpos == 0) begin
          wpos  = j;
          wd_at = Wdata;
          wn_at = Wdno;
        end
      end
      if (mode == 1) begin
        case (j)
          3: begin start = 1'b1; a = 8'd9; b = 8'd9; dest = 2'd3; hi = ~hii; end
          5: start = 1'b0;
          9: start = 1'b1;
          10: start = 1'b0;
          default: ;
        endcase
      end
      @(posedge clk); #1;
    end
    check({tag, ".wcount"}, wcnt, 1);
    check({tag, ".wlat"}, wpos, 9);
    check({tag, ".busycyc"}, bcnt, 9);
    check({tag, ".wdata"}, wd_at, exp_wdata);
    check({tag, ".wdno"}, wn_at, exp_wdno);
    check({tag, ".prod"}, prod, exp_prod);
    check({tag, ".wdata_hold"}, Wdata, exp_wdata);
    check({tag, ".idle"}, {30'b0, busy, w}, 0);
  endtask

  initial begin
    logic wseen;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    start = 1'b0;
    a = '0; b = '0; dest = '0; hi = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.w", w, 0);
    check("rst.wdno", Wdno, 0);
    check("rst.wdata", Wdata, 0);
    check("rst.prod", prod, 0);

    run_op("m15x17", 8'd15, 8'd17, 2'd2, 1'b0, 0, 8'hFF, 16'h00FF, 2'd2);
`ifdef MUL_SIGNED_EN
    run_op("mFFhi", 8'hFF, 8'hFF, 2'd0, 1'b1, 0, 8'h00, 16'h0001, 2'd0);
    run_op("mFFlo", 8'hFF, 8'hFF, 2'd3, 1'b0, 0, 8'h01, 16'h0001, 2'd3);
`else
    run_op("mFFhi", 8'hFF, 8'hFF, 2'd0, 1'b1, 0, 8'hFE, 16'hFE01, 2'd0);
    run_op("mFFlo", 8'hFF, 8'hFF, 2'd3, 1'b0, 0, 8'h01, 16'hFE01, 2'd3);
`endif
    run_op("mzero", 8'h00, 8'hA5, 2'd1, 1'b0, 0, 8'h00, 16'h0000, 2'd1);
    run_op("ignore", 8'd3, 8'd4, 2'd1, 1'b0, 1, 8'h0C, 16'h000C, 2'd1);

    // Abort an operation mid-RUN with reset.
    a = 8'h10; b = 8'h10; dest = 2'd2; hi = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort.busy_before", busy, 1);
    reset = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.w", w, 0);
    check("abort.wdno", Wdno, 0);
    check("abort.wdata", Wdata, 0);
    check("abort.prod", prod, 0);
    wseen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (w || busy) wseen = 1'b1;
    end
    reset = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (w || busy) wseen = 1'b1;
    end
    check("abort.nowrite", wseen, 0);
    run_op("m2x3", 8'd2, 8'd3, 2'd0, 1'b0, 0, 8'h06, 16'h0006, 2'd0);

`ifdef MUL_SIGNED_EN
    run_op("sneg2x3", 8'hFE, 8'h03, 2'd1, 1'b1, 0, 8'hFF, 16'hFFFA, 2'd1);
`else
    run_op("uFEx3", 8'hFE, 8'h03, 2'd1, 1'b1, 0, 8'h02, 16'h02FA, 2'd1);
`endif
    run_op("m80x80", 8'h80, 8'h80, 2'd2, 1'b1, 0, 8'h40, 16'h4000, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
